// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the IF fetch stage: FSM states, reset PC, NOP encoding,
// and the word-alignment helper used on redirect targets.
package if_fetch_unit_pkg;

    localparam int DATA_SIZE = 32;

    localparam logic [DATA_SIZE-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [DATA_SIZE-1:0] DEF_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } if_state_e;

    function automatic logic [DATA_SIZE-1:0] align_word(input logic [DATA_SIZE-1:0] addr);
        return {addr[DATA_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// I-cache request/response bus: level request held until the one-cycle response strobe.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic                 req;
    logic [DATA_SIZE-1:0] addr;
    logic                 rvalid;
    logic [DATA_SIZE-1:0] rdata;

    modport master (output req, addr, input rvalid, rdata);
    modport slave  (input req, addr, output rvalid, rdata);

endinterface

// File: rtl/if_fetch_unit_pc_gen.sv
// Combinational next-PC helpers: redirect qualification, jalr-over-branch priority,
// target alignment and the wrapping pc+4 adder.
module if_fetch_unit_pc_gen
    import if_fetch_unit_pkg::*;
(
    input  logic [DATA_SIZE-1:0] i_pc,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [DATA_SIZE-1:0] i_branch_target,
    input  logic                 i_flush_jalr,
    input  logic [DATA_SIZE-1:0] i_jalr_target,
    output logic                 o_redirect,
    output logic [DATA_SIZE-1:0] o_target,
    output logic [DATA_SIZE-1:0] o_pc_plus4
);

    // A stalled pipeline ignores redirects; the source keeps them asserted until released.
    assign o_redirect = !i_stall && (i_flush || i_flush_jalr);
    assign o_target   = align_word(i_flush_jalr ? i_jalr_target : i_branch_target);
    assign o_pc_plus4 = i_pc + 32'd4;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, keeps one I-cache request outstanding, and presents the fetched
// instruction (or a held copy while stalled) to the IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [DATA_SIZE-1:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [DATA_SIZE-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_address_rst,
    input  logic                 i_dstall,
    input  logic                 i_wfi_stall,
    input  logic                 i_flush,
    input  logic [DATA_SIZE-1:0] i_branch_target,
    input  logic                 i_flush_jalr,
    input  logic [DATA_SIZE-1:0] i_jalr_target,
    if_fetch_unit_if.master      icache,
    output logic [DATA_SIZE-1:0] o_pc_added,
    output logic [DATA_SIZE-1:0] o_icache_out,
    output logic                 o_istall
);

    if_state_e            r_state;
    logic [DATA_SIZE-1:0] r_pc;
    logic [DATA_SIZE-1:0] r_req_addr;
    logic [DATA_SIZE-1:0] r_buffer;

    logic                 w_stall;
    logic                 w_redirect;
    logic [DATA_SIZE-1:0] w_target;
    logic [DATA_SIZE-1:0] w_pc_plus4;
    logic                 w_outstanding;

    assign w_stall = i_dstall || i_wfi_stall;

    if_fetch_unit_pc_gen u_pc_gen (
        .i_pc            (r_pc),
        .i_stall         (w_stall),
        .i_flush         (i_flush),
        .i_branch_target (i_branch_target),
        .i_flush_jalr    (i_flush_jalr),
        .i_jalr_target   (i_jalr_target),
        .o_redirect      (w_redirect),
        .o_target        (w_target),
        .o_pc_plus4      (w_pc_plus4)
    );

    // A request still waiting for its response cannot be withdrawn; it must be drained.
    assign w_outstanding = ((r_state == FETCH) || (r_state == DISCARD)) && !icache.rvalid;

    assign icache.req  = (r_state == FETCH) || (r_state == DISCARD);
    assign icache.addr = r_req_addr;

    // Fetch FSM with PC, request address and stall buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_buffer   <= NOP_INSTR;
        end else if (i_address_rst) begin
            r_pc     <= RESET_PC;
            r_buffer <= NOP_INSTR;
            if (w_outstanding) begin
                r_state <= DISCARD;
            end else begin
                r_state    <= BOOT;
                r_req_addr <= RESET_PC;
            end
        end else if (w_redirect) begin
            r_pc     <= w_target;
            r_buffer <= NOP_INSTR;
            if (w_outstanding) begin
                r_state <= DISCARD;
            end else begin
                r_state    <= FETCH;
                r_req_addr <= w_target;
            end
        end else begin
            case (r_state)
                BOOT: begin
                    r_state    <= FETCH;
                    r_req_addr <= r_pc;
                end
                FETCH: begin
                    if (icache.rvalid && w_stall) begin
                        r_buffer <= icache.rdata;
                        r_state  <= HOLD;
                    end else if (icache.rvalid) begin
                        r_pc       <= w_pc_plus4;
                        r_req_addr <= w_pc_plus4;
                    end
                end
                HOLD: begin
                    if (!w_stall) begin
                        r_pc       <= w_pc_plus4;
                        r_req_addr <= w_pc_plus4;
                        r_state    <= FETCH;
                    end
                end
                DISCARD: begin
                    if (icache.rvalid) begin
                        r_req_addr <= r_pc;
                        r_state    <= FETCH;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    // Presented instruction; a redirect cycle shows an unstalled NOP so IF/ID flushes.
    always_comb begin
        o_icache_out = NOP_INSTR;
        o_pc_added   = 32'd0;
        o_istall     = 1'b1;
        if (i_address_rst) begin
            o_istall = 1'b1;
        end else if (w_redirect) begin
            o_istall = 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (icache.rvalid) begin
                        o_istall     = 1'b0;
                        o_icache_out = icache.rdata;
                        o_pc_added   = w_pc_plus4;
                    end else begin
                        o_istall = 1'b1;
                    end
                end
                HOLD: begin
                    o_istall     = 1'b0;
                    o_icache_out = r_buffer;
                    o_pc_added   = w_pc_plus4;
                end
                default: o_istall = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a variable-latency I-cache model.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        address_rst = 1'b0;
    logic        dstall = 1'b0;
    logic        wfi_stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        flush_jalr = 1'b0;
    logic [31:0] jalr_target = 32'd0;
    logic [31:0] pc_added;
    logic [31:0] icache_out;
    logic        istall;

    int n_checks = 0;
    int n_errors = 0;
    int lat = 1;
    int cnt;
    logic        busy;
    logic [31:0] cur_addr;

    if_fetch_unit_if icache ();

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .i_address_rst   (address_rst),
        .i_dstall        (dstall),
        .i_wfi_stall     (wfi_stall),
        .i_flush         (flush),
        .i_branch_target (branch_target),
        .i_flush_jalr    (flush_jalr),
        .i_jalr_target   (jalr_target),
        .icache          (icache),
        .o_pc_added      (pc_added),
        .o_icache_out    (icache_out),
        .o_istall        (istall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0010_0113;
            32'h0000_0008: return 32'h0020_81B3;
            default:       return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    // Cache model: response 'lat' cycles after the request is first seen, one-cycle strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            icache.rvalid <= 1'b0;
            icache.rdata  <= 32'd0;
            busy          <= 1'b0;
            cnt           <= 0;
            cur_addr      <= 32'd0;
        end else if (icache.rvalid) begin
            icache.rvalid <= 1'b0;
            busy          <= 1'b0;
        end else if (busy) begin
            if (cnt <= 1) begin
                icache.rvalid <= 1'b1;
                icache.rdata  <= mem(cur_addr);
            end
            cnt <= cnt - 1;
        end else if (icache.req) begin
            cur_addr <= icache.addr;
            if (lat <= 1) begin
                icache.rvalid <= 1'b1;
                icache.rdata  <= mem(icache.addr);
            end else begin
                busy <= 1'b1;
                cnt  <= lat - 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        check_val({tag, " req"}, {31'd0, icache.req}, {31'd0, req});
        if (req) check_val({tag, " addr"}, icache.addr, addr);
    endtask

    task automatic chk_out(input string tag, input logic st, input logic [31:0] out,
                           input logic [31:0] pca);
        check_val({tag, " istall"}, {31'd0, istall}, {31'd0, st});
        check_val({tag, " out"}, icache_out, out);
        if (!st && out != 32'h0000_0013) check_val({tag, " pc_added"}, pc_added, pca);
    endtask

    initial begin
        cyc(); cyc(); #1;
        check_val("rst req", {31'd0, icache.req}, 32'd0);
        check_val("rst addr", icache.addr, 32'h0000_0000);
        check_val("rst pc_added", pc_added, 32'd0);
        chk_out("rst", 1'b1, 32'h0000_0013, 32'd0);
        // cycle 0: idle boot cycle
        rst = 1'b0; #1;
        chk_req("c0", 1'b0, 32'd0);
        chk_out("c0", 1'b1, 32'h0000_0013, 32'd0);
        cyc(); #1; chk_req("c1", 1'b1, 32'h0);
        cyc(); #1; chk_out("c2", 1'b0, 32'h0050_0093, 32'h4);
        cyc(); #1; chk_req("c3", 1'b1, 32'h4); chk_out("c3", 1'b1, 32'h13, 32'd0);
        cyc(); #1; chk_out("c4", 1'b0, 32'h0010_0113, 32'h8);
        cyc(); #1; chk_req("c5", 1'b1, 32'h8);
        // Dstall on the response for 0x8: presented, then held
        cyc(); dstall = 1'b1; #1; chk_out("c6", 1'b0, 32'h0020_81B3, 32'hC);
        for (int i = 7; i <= 9; i++) begin
            cyc(); #1;
            chk_req($sformatf("hold%0d", i), 1'b0, 32'd0);
            chk_out($sformatf("hold%0d", i), 1'b0, 32'h0020_81B3, 32'hC);
        end
        cyc(); dstall = 1'b0; #1; chk_out("c10", 1'b0, 32'h0020_81B3, 32'hC);
        cyc(); #1; chk_req("c11", 1'b1, 32'hC);
        cyc(); lat = 3; #1; chk_out("c12", 1'b0, 32'hC0DE_000C, 32'h10);
        cyc(); #1; chk_req("c13", 1'b1, 32'h10);
        // branch redirect while 0x10 outstanding
        cyc(); flush = 1'b1; branch_target = 32'h102; #1;
        chk_out("c14 redir", 1'b0, 32'h13, 32'd0);
        cyc(); flush = 1'b0; #1; chk_req("c15", 1'b1, 32'h10); chk_out("c15", 1'b1, 32'h13, 32'd0);
        cyc(); lat = 1; #1; chk_req("c16", 1'b1, 32'h10); chk_out("c16 drop", 1'b1, 32'h13, 32'd0);
        cyc(); #1; chk_req("c17", 1'b1, 32'h100);
        cyc(); #1; chk_out("c18", 1'b0, 32'hC0DE_0100, 32'h104);
        // simultaneous flush/flush_jalr, first under Dstall
        cyc(); dstall = 1'b1; flush = 1'b1; branch_target = 32'h200;
        flush_jalr = 1'b1; jalr_target = 32'h300; #1;
        chk_req("c19", 1'b1, 32'h104); chk_out("c19", 1'b1, 32'h13, 32'd0);
        cyc(); #1; chk_out("c20 ignored", 1'b0, 32'hC0DE_0104, 32'h108);
        cyc(); dstall = 1'b0; #1; chk_out("c21 redir", 1'b0, 32'h13, 32'd0);
        cyc(); flush = 1'b0; flush_jalr = 1'b0; #1; chk_req("c22 jalr", 1'b1, 32'h300);
        cyc(); #1; chk_out("c23", 1'b0, 32'hC0DE_0300, 32'h304);
        cyc(); flush = 1'b1; branch_target = 32'h40; #1; chk_req("c24", 1'b1, 32'h304);
        cyc(); flush = 1'b0; lat = 3; #1; chk_out("c25 drop", 1'b1, 32'h13, 32'd0);
        cyc(); #1; chk_req("c26", 1'b1, 32'h40);
        // address_rst with request outstanding
        cyc(); address_rst = 1'b1; #1; chk_out("c27 arst", 1'b1, 32'h13, 32'd0);
        cyc(); address_rst = 1'b0; #1; chk_req("c28", 1'b1, 32'h40);
        cyc(); lat = 1; #1; chk_out("c29 drop", 1'b1, 32'h13, 32'd0);
        cyc(); #1; chk_req("c30", 1'b1, 32'h0);
        cyc(); #1; chk_out("c31", 1'b0, 32'h0050_0093, 32'h4);
        // jalr to an unaligned top-of-memory target, then wrap
        cyc(); flush_jalr = 1'b1; jalr_target = 32'hFFFF_FFFF; #1; chk_req("c32", 1'b1, 32'h4);
        cyc(); flush_jalr = 1'b0; #1; chk_out("c33 drop", 1'b1, 32'h13, 32'd0);
        cyc(); #1; chk_req("c34", 1'b1, 32'hFFFF_FFFC);
        cyc(); #1; chk_out("c35 wrap", 1'b0, 32'h3F21_FFFC, 32'h0);
        check_val("c35 pc_added", pc_added, 32'h0);
        cyc(); #1; chk_req("c36", 1'b1, 32'h0);
        cyc(); #1; chk_out("c37", 1'b0, 32'h0050_0093, 32'h4);
        // address_rst from HOLD (no request outstanding) returns to BOOT
        cyc(); wfi_stall = 1'b1; #1; chk_req("c38", 1'b1, 32'h4);
        cyc(); #1; chk_out("c39", 1'b0, 32'h0010_0113, 32'h8);
        cyc(); address_rst = 1'b1; #1; chk_out("c40 arst", 1'b1, 32'h13, 32'd0);
        cyc(); address_rst = 1'b0; wfi_stall = 1'b0; #1;
        chk_req("c41 boot", 1'b0, 32'd0); chk_out("c41", 1'b1, 32'h13, 32'd0);
        cyc(); #1; chk_req("c42", 1'b1, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
